ext_sram_ctrl: RTL

//  Parametrised single-clock external SRAM model: separate write and read request channels,

---
 rtl/ext_sram_pkg.sv | 17 +
 rtl/ext_sram_lat_fsm.sv | 67 ++++++
 rtl/ext_sram_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ext_sram_pkg.sv
// Shared types and constants for the external SRAM model.
package ext_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  localparam int LAT_W  = 4;
  localparam int STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

endpackage

// File: rtl/ext_sram_lat_fsm.sv
// Per-channel request FSM: counts LAT cycles after valid, then pulses a registered ready.
module ext_sram_lat_fsm
  import ext_sram_pkg::*;
#(
  parameter int LAT      = 2,
  parameter bit HAS_RESP = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic resp_done,
  output logic req_ready
);

  localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(LAT);

  chan_state_e      state_reg, state_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic             ready_reg, ready_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = WAIT;
          cnt_next   = LAT_W'(1);
          ready_next = (LAT_CNT == LAT_W'(1));
        end
      end
      WAIT: begin
        // A dropped valid abandons the request without ever raising ready.
        if (!req_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (ready_reg) begin
          state_next = HAS_RESP ? RESP : IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + LAT_W'(1);
          ready_next = ((cnt_reg + LAT_W'(1)) == LAT_CNT);
        end
      end
      RESP: begin
        if (resp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = ready_reg;

endmodule

// File: rtl/ext_sram_ctrl.sv
// External SRAM model with latency-controlled write/read channels and a backpressured response.
// Defining EXT_SRAM_STATS_EN adds saturating write/read/stall counters as extra outputs.
module ext_sram_ctrl
  import ext_sram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 2,
  parameter bit RW_BYPASS  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready
`ifdef EXT_SRAM_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_wr_cnt,
  output logic [STAT_W-1:0]     stat_rd_cnt,
  output logic [STAT_W-1:0]     stat_stall_cnt
`endif
);

  localparam int NB = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $error("ext_sram_ctrl: DATA_W must be a positive multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_lat
    $error("ext_sram_ctrl: RD_LATENCY must be within 1..15");
  end
  if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_wr_lat
    $error("ext_sram_ctrl: WR_LATENCY must be within 1..15");
  end

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              wr_fire, rd_fire, rsp_fire, bypass_hit;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_valid_reg, rsp_valid_next;

  ext_sram_lat_fsm #(.LAT(WR_LATENCY), .HAS_RESP(1'b0)) u_wr_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (wr_valid),
    .resp_done (1'b0),
    .req_ready (wr_ready)
  );

  ext_sram_lat_fsm #(.LAT(RD_LATENCY), .HAS_RESP(1'b1)) u_rd_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rd_valid),
    .resp_done (rsp_fire),
    .req_ready (rd_ready)
  );

  // A reset edge aborts an in-flight write even if ready was already up.
  assign wr_fire    = wr_ready & wr_valid & rst_n;
  assign rd_fire    = rd_ready & rd_valid;
  assign rsp_fire   = rsp_valid_reg & rsp_ready;
  assign bypass_hit = RW_BYPASS && wr_fire && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_strb[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign rd_word[gi*8 +: 8] = (bypass_hit && wr_strb[gi]) ? wr_data[gi*8 +: 8]
                                                            : mem[rd_addr][gi*8 +: 8];
  end

  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    if (rd_fire) begin
      rsp_valid_next = 1'b1;
      rsp_data_next  = rd_word;
    end else if (rsp_fire) begin
      rsp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

`ifdef EXT_SRAM_STATS_EN
  logic [STAT_W-1:0] stat_wr_reg, stat_rd_reg, stat_stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_wr_reg    <= '0;
      stat_rd_reg    <= '0;
      stat_stall_reg <= '0;
    end else begin
      stat_wr_reg    <= sat_inc(stat_wr_reg, wr_fire);
      stat_rd_reg    <= sat_inc(stat_rd_reg, rd_fire);
      stat_stall_reg <= sat_inc(stat_stall_reg, rsp_valid_reg & ~rsp_ready);
    end
  end

  assign stat_wr_cnt    = stat_wr_reg;
  assign stat_rd_cnt    = stat_rd_reg;
  assign stat_stall_cnt = stat_stall_reg;
`endif

endmodule
